// File: rtl/ro_worker_pkg.sv
// Shared constants and FSM encoding for the ring-oscillator frequency meter.
package ro_worker_pkg;

  // Default gate window (2^10 clk cycles) and counter width.
  localparam int unsigned GATE_LOG2_DEF = 10;
  localparam int unsigned CNT_W_DEF     = 16;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StArm   = ST_ARM,
    StGate  = ST_GATE,
    StLatch = ST_LATCH
  } meter_state_e;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Host-side control and readout signals of the frequency meter.
interface ro_freq_meter_if
  import ro_worker_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic             continuous;
  logic             shift;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             ser_out;

  // Host side: issues commands, reads results.
  modport master (
    output start, continuous, shift,
    input  busy, done, count, overflow, ser_out
  );

  // Meter side.
  modport slave (
    input  start, continuous, shift,
    output busy, done, count, overflow, ser_out
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop; flags a rising edge of the async input.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_edge
);

  (* async_reg = "true", dont_touch = "true" *) logic r_s1;
  (* async_reg = "true", dont_touch = "true" *) logic r_s2;
  logic r_s3;

  // Synchroniser chain followed by the history flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated frequency counter: counts oscillator rising edges over 2^GATE_LOG2 clk cycles,
// latches the saturating result and offers it for MSB-first serial readout.
module ro_freq_meter
  import ro_worker_pkg::*;
#(
  parameter int unsigned GATE_LOG2 = GATE_LOG2_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_osc_in,
  ro_freq_meter_if.slave io_bus
);

  localparam logic [GATE_LOG2-1:0] GateLast = '1;
  localparam logic [CNT_W-1:0]     CntMax   = '1;

  meter_state_e           r_state;
  logic [GATE_LOG2-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic                   r_ovf_flag;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_shift;

  logic                   w_edge;
  logic                   w_gate_end;
  logic [CNT_W-1:0]       w_edge_cnt_next;
  logic                   w_ovf_next;

  sync_edge_detect u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_osc_in),
    .o_edge  (w_edge)
  );

  // Saturating edge count including this cycle's edge, so the last gate cycle is
  // captured by the latch on the same clock edge.
  always_comb begin
    w_edge_cnt_next = r_edge_cnt;
    w_ovf_next      = r_ovf_flag;
    if (r_state == StGate && w_edge) begin
      if (r_edge_cnt == CntMax) begin
        w_ovf_next = 1'b1;
      end else begin
        w_edge_cnt_next = r_edge_cnt + 1'b1;
      end
    end
  end

  assign w_gate_end = (r_state == StGate) && (r_gate_cnt == GateLast);

  // Measurement FSM with gate counter, edge counter and result registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_flag <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) r_state <= StArm;
        end
        StArm: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_ovf_flag <= 1'b0;
          r_state    <= StGate;
        end
        StGate: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          r_edge_cnt <= w_edge_cnt_next;
          r_ovf_flag <= w_ovf_next;
          if (w_gate_end) begin
            r_count    <= w_edge_cnt_next;
            r_overflow <= w_ovf_next;
            r_state    <= StLatch;
          end
        end
        StLatch: begin
          r_state <= io_bus.continuous ? StArm : StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Serial readout register; a result load beats a simultaneous shift.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
    end else if (w_gate_end) begin
      r_shift <= w_edge_cnt_next;
    end else if (io_bus.shift) begin
      r_shift <= {r_shift[CNT_W-2:0], 1'b0};
    end
  end

  assign io_bus.busy     = (r_state != StIdle);
  assign io_bus.done     = (r_state == StLatch);
  assign io_bus.count    = r_count;
  assign io_bus.overflow = r_overflow;
  assign io_bus.ser_out  = r_shift[CNT_W-1];

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench: two meter instances (10/16 and 6/4) against a window-arithmetic model.
module tb_ro_freq_meter;
  import ro_worker_pkg::*;

  localparam int GA = 10;
  localparam int CA = 16;
  localparam int GB = 6;
  localparam int CB = 4;
  localparam int WA = 1 << GA;
  localparam int WB = 1 << GB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, osc_a, osc_b;

  ro_freq_meter_if #(.CNT_W(CA)) bus_a ();
  ro_freq_meter_if #(.CNT_W(CB)) bus_b ();

  ro_freq_meter #(.GATE_LOG2(GA), .CNT_W(CA)) dut_a (
    .i_clk    (clk),
    .i_reset  (rst_a),
    .i_osc_in (osc_a),
    .io_bus   (bus_a)
  );

  ro_freq_meter #(.GATE_LOG2(GB), .CNT_W(CB)) dut_b (
    .i_clk    (clk),
    .i_reset  (rst_b),
    .i_osc_in (osc_b),
    .io_bus   (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Stimulus: pending values are applied at the start of the next cycle.
  bit pend_start [2], pend_cont [2], pend_shift [2], pend_rst [2];
  bit cur_start [2], cur_cont [2], cur_shift [2], cur_rst [2], cur_osc [2];
  int osc_mode [2];  // 0 low, 1 high, 2 period-4 square, 3 period-2 square, 4 random
  int osc_t0 [2];

  // Reference model: a measurement launched in cycle s gates cycles s+2..s+W+1 and
  // an oscillator rise driven in cycle c is seen as an edge in cycle c+2.
  int W [2], MX [2];
  bit act [2];
  int ws [2], raw [2];
  int exp_cnt [2], exp_ovf [2], sr [2];
  bit e1 [2], e2 [2], e3 [2];
  int done_seen [2], first_done [2], last_done [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit gen_osc(input int d, input int n);
    int rel;
    rel = n - osc_t0[d];
    case (osc_mode[d])
      0: return 1'b0;
      1: return 1'b1;
      2: return (rel & 3) < 2;
      3: return (rel & 1) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic bit exp_done(input int d);
    return act[d] && ((cyc - ws[d]) == W[d] + 2);
  endfunction

  // Move the model across the clock edge that ends cycle 'cyc'.
  task automatic advance(input int d);
    int  k;
    bit  eff, edge_p, load;
    eff    = cur_rst[d] ? 1'b0 : cur_osc[d];
    edge_p = e2[d] & ~e3[d];
    e3[d]  = e2[d];
    e2[d]  = e1[d];
    e1[d]  = eff;
    load   = 1'b0;
    if (cur_rst[d]) begin
      act[d] = 1'b0; exp_cnt[d] = 0; exp_ovf[d] = 0; sr[d] = 0;
      e1[d] = 1'b0; e2[d] = 1'b0; e3[d] = 1'b0;
    end else begin
      if (act[d]) begin
        k = cyc - ws[d];
        if (k >= 2 && k <= W[d] + 1 && edge_p) raw[d]++;
        if (k == W[d] + 1) begin
          load       = 1'b1;
          exp_cnt[d] = (raw[d] > MX[d]) ? MX[d] : raw[d];
          exp_ovf[d] = (raw[d] > MX[d]) ? 1 : 0;
          sr[d]      = exp_cnt[d];
        end
        if (k == W[d] + 2) begin
          if (cur_cont[d]) begin
            ws[d] = cyc; raw[d] = 0;
          end else begin
            act[d] = 1'b0;
          end
        end
      end else if (cur_start[d]) begin
        act[d] = 1'b1; ws[d] = cyc; raw[d] = 0;
      end
      if (!load && cur_shift[d]) sr[d] = (sr[d] * 2) % (MX[d] + 1);
    end
  endtask

  task automatic drive();
    rst_a = cur_rst[0]; osc_a = cur_osc[0];
    bus_a.start = cur_start[0]; bus_a.continuous = cur_cont[0]; bus_a.shift = cur_shift[0];
    rst_b = cur_rst[1]; osc_b = cur_osc[1];
    bus_b.start = cur_start[1]; bus_b.continuous = cur_cont[1]; bus_b.shift = cur_shift[1];
  endtask

  task automatic check_all();
    check("a.busy", 32'(bus_a.busy), 32'(act[0]));
    check("a.done", 32'(bus_a.done), 32'(exp_done(0)));
    check("a.count", 32'(bus_a.count), 32'(exp_cnt[0]));
    check("a.overflow", 32'(bus_a.overflow), 32'(exp_ovf[0]));
    check("a.ser_out", 32'(bus_a.ser_out), 32'((sr[0] >> (CA - 1)) & 1));
    check("b.busy", 32'(bus_b.busy), 32'(act[1]));
    check("b.done", 32'(bus_b.done), 32'(exp_done(1)));
    check("b.count", 32'(bus_b.count), 32'(exp_cnt[1]));
    check("b.overflow", 32'(bus_b.overflow), 32'(exp_ovf[1]));
    check("b.ser_out", 32'(bus_b.ser_out), 32'((sr[1] >> (CB - 1)) & 1));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) advance(d);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      cur_start[d] = pend_start[d];
      cur_cont[d]  = pend_cont[d];
      cur_shift[d] = pend_shift[d];
      cur_rst[d]   = pend_rst[d];
      cur_osc[d]   = gen_osc(d, cyc);
    end
    drive();
    @(negedge clk);
    check_all();
    if (bus_a.done === 1'b1) begin
      if (done_seen[0] == 0) first_done[0] = cyc;
      last_done[0] = cyc; done_seen[0]++;
    end
    if (bus_b.done === 1'b1) begin
      if (done_seen[1] == 0) first_done[1] = cyc;
      last_done[1] = cyc; done_seen[1]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Quiet the oscillator, then start a window with the oscillator phase aligned to it.
  task automatic launch(input int d, input int mode);
    osc_mode[d] = 0;
    run(3);
    pend_start[d] = 1'b1;
    osc_mode[d]   = mode;
    osc_t0[d]     = cyc + 1;
    run(1);
    pend_start[d] = 1'b0;
  endtask

  logic [15:0] bits;

  initial begin
    W[0] = WA; MX[0] = (1 << CA) - 1;
    W[1] = WB; MX[1] = (1 << CB) - 1;
    for (int d = 0; d < 2; d++) begin
      cur_rst[d] = 1'b1; pend_rst[d] = 1'b1;
      cur_start[d] = 1'b0; cur_cont[d] = 1'b0; cur_shift[d] = 1'b0; cur_osc[d] = 1'b0;
      pend_start[d] = 1'b0; pend_cont[d] = 1'b0; pend_shift[d] = 1'b0;
      osc_mode[d] = 0; osc_t0[d] = 0;
      act[d] = 1'b0; ws[d] = 0; raw[d] = 0; exp_cnt[d] = 0; exp_ovf[d] = 0; sr[d] = 0;
      e1[d] = 1'b0; e2[d] = 1'b0; e3[d] = 1'b0;
      done_seen[d] = 0; first_done[d] = 0; last_done[d] = 0;
    end
    drive();

    // Reset state.
    run(3);
    pend_rst[0] = 1'b0; pend_rst[1] = 1'b0;
    run(2);
    check("rst.a.count", 32'(bus_a.count), 32'd0);
    check("rst.a.busy", 32'(bus_a.busy), 32'd0);

    // Period-4 square wave over a full window: 256 edges, done 1026 cycles after start.
    done_seen[0] = 0;
    launch(0, 2);
    bits = 16'(cyc);
    run(WA + 3);
    check("sq4.count", 32'(bus_a.count), 32'd256);
    check("sq4.overflow", 32'(bus_a.overflow), 32'd0);
    check("sq4.done_cycle", 32'(first_done[0] - int'(bits)), 32'(WA + 2));

    // Serial readout of 0x0100, MSB first.
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      pend_shift[0] = 1'b1;
      tick();
      bits = {bits[14:0], bus_a.ser_out};
    end
    pend_shift[0] = 1'b0;
    check("ser.pattern", 32'(bits), 32'h0100);

    // Shift held through the load edge: the load must win.
    pend_shift[0] = 1'b1;
    launch(0, 2);
    run(WA + 1);
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      bits = {bits[14:0], bus_a.ser_out};
    end
    pend_shift[0] = 1'b0;
    check("ser.load_wins", 32'(bits), 32'h0100);

    // Oscillator held low, then held high.
    launch(0, 0);
    run(WA + 3);
    check("low.count", 32'(bus_a.count), 32'd0);
    check("low.overflow", 32'(bus_a.overflow), 32'd0);
    osc_mode[0] = 1;
    run(6);
    pend_start[0] = 1'b1;
    run(1);
    pend_start[0] = 1'b0;
    run(WA + 3);
    check("high.count", 32'(bus_a.count), 32'd0);
    check("high.overflow", 32'(bus_a.overflow), 32'd0);

    // Saturation on the 4-bit instance, then a clean window.
    launch(1, 3);
    run(WB + 3);
    check("sat.count", 32'(bus_b.count), 32'd15);
    check("sat.overflow", 32'(bus_b.overflow), 32'd1);
    launch(1, 0);
    run(WB + 3);
    check("unsat.count", 32'(bus_b.count), 32'd0);
    check("unsat.overflow", 32'(bus_b.overflow), 32'd0);

    // Continuous mode over three windows, dropped during the third.
    done_seen[1] = 0;
    pend_cont[1] = 1'b1;
    launch(1, 4);
    run(2 * (WB + 2) + 20);
    pend_cont[1] = 1'b0;
    run(WB + 10);
    check("cont.done_count", 32'(done_seen[1]), 32'd3);
    check("cont.spacing", 32'(last_done[1] - first_done[1]), 32'(2 * (WB + 2)));
    check("cont.idle", 32'(bus_b.busy), 32'd0);

    // Reset mid-gate: idle next cycle and no done for the aborted window.
    launch(0, 2);
    run(100);
    done_seen[0] = 0;
    pend_rst[0] = 1'b1;
    run(1);
    pend_rst[0] = 1'b0;
    run(1);
    check("abort.busy", 32'(bus_a.busy), 32'd0);
    check("abort.count", 32'(bus_a.count), 32'd0);
    check("abort.ser_out", 32'(bus_a.ser_out), 32'd0);
    run(WA + 10);
    check("abort.no_done", 32'(done_seen[0]), 32'd0);

    // Randomised traffic on both instances.
    for (int it = 0; it < 300; it++) begin
      for (int d = 0; d < 2; d++) begin
        pend_start[d] = ($urandom_range(0, 7) == 0);
        pend_cont[d]  = ($urandom_range(0, 3) == 0);
        pend_shift[d] = ($urandom_range(0, 2) == 0);
        pend_rst[d]   = ($urandom_range(0, 199) == 0);
        osc_mode[d]   = int'($urandom_range(0, 4));
      end
      run(int'($urandom_range(1, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
